// File: rtl/rpi_reg_select_tx.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | rpi_reg_select_tx : RPi register-select link initiator (3-nibble frames) |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rpi_reg_select_tx #(
   parameter int CLK_DIV    = 4,
   parameter int RST_CYCLES = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       link_resync,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_reg,
   input  logic [7:0] req_data,
   output logic       done,
   output logic       busy,
   output logic       r_reset,
   output logic       r_clk,
   output logic [3:0] r_dout
);

   localparam int CNT_MAX = (CLK_DIV > RST_CYCLES) ? CLK_DIV : RST_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] C_DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] C_RST_LAST = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] C_ONE      = CW'(1);

   typedef enum logic [2:0] {
      S_LRST  = 3'd0,
      S_IDLE  = 3'd1,
      S_SETUP = 3'd2,
      S_HIGH  = 3'd3,
      S_LOW   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_phase;
   logic          r_resync_pend;
   logic [7:0]    r_shift;
   logic          r_ready;
   logic          w_div_last;
   logic          w_accept;

   // A resync in the same cycle as a request withdraws readiness, so the host
   // never sees a handshake that the block then ignores.
   assign req_ready  = r_ready && !link_resync;
   assign w_accept   = req_valid && req_ready;
   assign w_div_last = (r_cnt == C_DIV_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_LRST;
         r_cnt         <= '0;
         r_phase       <= 2'd0;
         r_resync_pend <= 1'b0;
         r_shift       <= 8'h00;
         r_ready       <= 1'b0;
         r_reset       <= 1'b1;
         r_clk         <= 1'b0;
         r_dout        <= 4'h0;
         done          <= 1'b0;
         busy          <= 1'b1;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_LRST: begin
               r_resync_pend <= 1'b0;
               if (link_resync) begin
                  r_cnt <= '0;
               end else if (r_cnt == C_RST_LAST) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_reset <= 1'b0;
                  busy    <= 1'b0;
                  r_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            S_IDLE: begin
               if (link_resync) begin
                  r_state <= S_LRST;
                  r_cnt   <= '0;
                  r_reset <= 1'b1;
                  r_dout  <= 4'h0;
                  busy    <= 1'b1;
                  r_ready <= 1'b0;
               end else if (w_accept) begin
                  r_state <= S_SETUP;
                  r_cnt   <= '0;
                  r_phase <= 2'd0;
                  r_shift <= req_data;
                  r_dout  <= req_reg;
                  busy    <= 1'b1;
                  r_ready <= 1'b0;
               end
            end
            S_SETUP: begin
               r_resync_pend <= r_resync_pend | link_resync;
               if (w_div_last) begin
                  r_state <= S_HIGH;
                  r_cnt   <= '0;
                  r_clk   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            S_HIGH: begin
               r_resync_pend <= r_resync_pend | link_resync;
               if (w_div_last) begin
                  r_state <= S_LOW;
                  r_cnt   <= '0;
                  r_clk   <= 1'b0;
                  // Next nibble goes out right after the falling edge; the last
                  // nibble of the frame simply stays on the bus.
                  if (r_phase != 2'd2) begin
                     r_dout  <= r_shift[7:4];
                     r_shift <= {r_shift[3:0], 4'h0};
                  end
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            S_LOW: begin
               r_resync_pend <= r_resync_pend | link_resync;
               if (w_div_last) begin
                  r_cnt <= '0;
                  if (r_phase == 2'd2) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                  end else begin
                     r_state <= S_SETUP;
                     r_phase <= r_phase + 2'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            S_DONE: begin
               r_cnt <= '0;
               if (r_resync_pend || link_resync) begin
                  r_state       <= S_LRST;
                  r_resync_pend <= 1'b0;
                  r_reset       <= 1'b1;
                  r_dout        <= 4'h0;
               end else begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= S_LRST;
               r_cnt   <= '0;
               r_reset <= 1'b1;
               r_clk   <= 1'b0;
               r_dout  <= 4'h0;
               busy    <= 1'b1;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rpi_reg_select_tx.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rpi_reg_select_tx : bench for the RPi register-select link initiator  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rpi_reg_select_tx;

   localparam int D = 4;
   localparam int R = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       link_resync = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [3:0] req_reg = 4'h0;
   logic [7:0] req_data = 8'h00;
   logic       done, busy, r_reset, r_clk;
   logic [3:0] r_dout;

   int n_checks = 0;
   int n_errors = 0;

   rpi_reg_select_tx #(.CLK_DIV(D), .RST_CYCLES(R)) dut (
      .clk(clk), .reset_n(reset_n), .link_resync(link_resync),
      .req_valid(req_valid), .req_ready(req_ready), .req_reg(req_reg),
      .req_data(req_data), .done(done), .busy(busy), .r_reset(r_reset),
      .r_clk(r_clk), .r_dout(r_dout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Behavioural receiver: mod-3 rising-edge counter, cleared by r_reset.
   int         rx_cnt = 0;
   logic [3:0] rx_sel = 4'h0, rx_hi = 4'h0;
   logic [7:0] rx_byte = 8'h00;
   logic [3:0] rx_log[$];
   logic [3:0] sel_hist[$];
   initial forever begin
      @(posedge r_clk or posedge r_reset);
      if (r_reset === 1'b1) rx_cnt = 0;
      else begin
         rx_log.push_back(r_dout);
         case (rx_cnt)
            0: begin rx_sel = r_dout; sel_hist.push_back(r_dout); end
            1: rx_hi = r_dout;
            default: rx_byte = {rx_hi, r_dout};
         endcase
         rx_cnt = (rx_cnt + 1) % 3;
      end
   end

   // Model: mode 0 = link reset, 1 = idle, 2 = frame. Inputs change only just
   // after a falling edge, so at each falling edge they equal what the last
   // rising edge sampled.
   int         m_mode = 0, m_rem = R, m_j = 0;
   bit         m_pend = 0;
   logic [3:0] m_nib[3];
   logic [3:0] m_last = 4'h0;
   initial forever begin
      int seg, idx;
      logic [3:0] e_dout;
      logic e_clk, e_done, e_rst, e_busy, e_rdy;
      @(negedge clk);
      if (!reset_n) begin
         m_mode = 0; m_rem = R; m_pend = 0; m_last = 4'h0;
      end else begin
         case (m_mode)
            0: if (link_resync) m_rem = R;
               else begin m_rem--; if (m_rem == 0) m_mode = 1; end
            1: if (link_resync) begin m_mode = 0; m_rem = R; m_last = 4'h0; end
               else if (req_valid) begin
                  m_mode = 2; m_j = 1; m_pend = 0;
                  m_nib[0] = req_reg; m_nib[1] = req_data[7:4]; m_nib[2] = req_data[3:0];
               end
            default: begin
               m_pend = m_pend | link_resync;
               if (m_j == 9 * D + 1) begin
                  if (m_pend) begin m_mode = 0; m_rem = R; m_last = 4'h0; end
                  else begin m_mode = 1; m_last = m_nib[2]; end
               end else m_j++;
            end
         endcase
      end
      e_rst = 1'b0; e_clk = 1'b0; e_done = 1'b0; e_busy = 1'b1; e_rdy = 1'b0; e_dout = 4'h0;
      if (m_mode == 0) e_rst = 1'b1;
      else if (m_mode == 1) begin
         e_busy = 1'b0; e_rdy = !link_resync; e_dout = m_last;
      end else if (m_j == 9 * D + 1) begin
         e_done = 1'b1; e_dout = m_nib[2];
      end else begin
         seg = (m_j - 1) / D;
         idx = (seg + 1) / 3;
         if (idx > 2) idx = 2;
         e_clk = (seg % 3 == 1);
         e_dout = m_nib[idx];
      end
      chk("r_reset", {31'd0, r_reset}, {31'd0, e_rst});
      chk("r_clk", {31'd0, r_clk}, {31'd0, e_clk});
      chk("r_dout", {28'd0, r_dout}, {28'd0, e_dout});
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("req_ready", {31'd0, req_ready}, {31'd0, e_rdy});
   end

   // Present a request (optionally with a simultaneous resync pulse) and hold
   // it until accepted; waited = rising edges that refused it.
   task automatic send(input logic [3:0] rg, input logic [7:0] d, input bit rs, output int waited);
      bit acc;
      @(negedge clk); #1;
      req_reg = rg; req_data = d; req_valid = 1'b1; link_resync = rs; waited = 0;
      forever begin
         #1 acc = req_ready;
         @(negedge clk); #1;
         link_resync = 1'b0;
         if (acc) break;
         waited++;
         if (waited > 200) begin chk("accept_timeout", 1, 0); break; end
      end
      req_valid = 1'b0; req_reg = ~rg; req_data = ~d;
   endtask

   task automatic wait_done(output int n);
      n = 1;
      while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("done_timeout", 1, 0);
   endtask

   task automatic pulse_resync();
      @(negedge clk); #1 link_resync = 1'b1;
      @(negedge clk); #1 link_resync = 1'b0;
   endtask

   initial begin
      int n, w;
      logic [3:0] exp3[6];
      exp3 = '{4'h3, 4'h1, 4'h2, 4'h7, 4'hE, 4'hF};

      // 1: reset release
      repeat (3) @(negedge clk);
      #1 reset_n = 1'b1;
      n = 0;
      forever begin
         @(posedge clk); n++;
         #1 if (r_reset == 1'b0 || n > 50) break;
      end
      chk("t1_rst_len", n, 8);
      @(negedge clk);
      chk("t1_ready", {31'd0, req_ready}, 1);
      chk("t1_rclk", {31'd0, r_clk}, 0);

      // 2: single frame A/5C
      send(4'hA, 8'h5C, 1'b0, w);
      wait_done(n);
      chk("t2_latency", n, 37);
      chk("t2_sel", {28'd0, rx_sel}, 32'hA);
      chk("t2_byte", {24'd0, rx_byte}, 32'h5C);

      // 3: back-to-back
      rx_log.delete(); sel_hist.delete();
      send(4'h3, 8'h12, 1'b0, w);
      send(4'h7, 8'hEF, 1'b0, w);
      chk("t3_wait", w, 36);
      wait_done(n);
      chk("t3_latency", n, 37);
      chk("t3_log_len", rx_log.size(), 6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("t3_nib%0d", i), (i < rx_log.size()) ? {28'd0, rx_log[i]} : 32'hFFFF, {28'd0, exp3[i]});
      chk("t3_sel_len", sel_hist.size(), 2);
      if (sel_hist.size() == 2) begin
         chk("t3_sel0", {28'd0, sel_hist[0]}, 32'h3);
         chk("t3_sel1", {28'd0, sel_hist[1]}, 32'h7);
      end

      // 4: resync mid-frame (phase 1), request held meanwhile
      sel_hist.delete();
      send(4'h2, 8'h34, 1'b0, w);
      repeat (13) @(negedge clk);
      pulse_resync();
      send(4'h5, 8'h66, 1'b0, w);
      chk("t4_wait", w, 29);
      wait_done(n);
      chk("t4_sel_len", sel_hist.size(), 2);
      chk("t4_sel", {28'd0, rx_sel}, 32'h5);
      chk("t4_byte", {24'd0, rx_byte}, 32'h66);

      // 5: resync and request in the same idle cycle
      send(4'hC, 8'h3B, 1'b1, w);
      chk("t5_wait", w, 9);
      wait_done(n);
      chk("t5_sel", {28'd0, rx_sel}, 32'hC);
      chk("t5_byte", {24'd0, rx_byte}, 32'h3B);

      // 6: reset_n during HIGH of phase 2
      send(4'h1, 8'hAB, 1'b0, w);
      repeat (29) @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("t6_rclk", {31'd0, r_clk}, 0);
      chk("t6_rreset", {31'd0, r_reset}, 1);
      chk("t6_busy", {31'd0, busy}, 1);
      chk("t6_dout", {28'd0, r_dout}, 0);
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;
      send(4'h9, 8'h00, 1'b0, w);
      chk("t6_wait", w, 7);
      wait_done(n);
      chk("t6_sel", {28'd0, rx_sel}, 32'h9);
      chk("t6_byte", {24'd0, rx_byte}, 32'h00);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
